// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared types, defaults and frame-size helper for the Sobel scan controller
package sobel_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } scan_state_t;

  localparam int IMG_W_DEF    = 256;
  localparam int IMG_H_DEF    = 256;
  localparam int PIPE_LAT_DEF = 2;

  // Number of interior (centre) pixels, i.e. windows per frame.
  function automatic int num_windows(input int img_w, input int img_h);
    return (img_w - 2) * (img_h - 2);
  endfunction

endpackage

// File: rtl/raster_counter.sv
// rtl/raster_counter.sv - interior-pixel raster walker producing the centre pixel address
module raster_counter
  import sobel_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              load,
  input  logic              advance,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  localparam logic [CW-1:0]     COL_FIRST = CW'(1);
  localparam logic [CW-1:0]     COL_LAST  = CW'(IMG_W - 2);
  localparam logic [RW-1:0]     ROW_FIRST = RW'(1);
  localparam logic [RW-1:0]     ROW_LAST  = RW'(IMG_H - 2);
  localparam logic [ADDR_W-1:0] W_STEP    = ADDR_W'(IMG_W);

  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wrap;

  assign wrap = (col_q == COL_LAST);

  // base_q tracks row*IMG_W so the next row start is an add, never a multiply.
  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    base_d = base_q;
    addr_d = addr_q;
    if (clear) begin
      col_d  = '0;
      row_d  = '0;
      base_d = '0;
      addr_d = '0;
    end else if (load) begin
      col_d  = COL_FIRST;
      row_d  = ROW_FIRST;
      base_d = W_STEP;
      addr_d = W_STEP + ADDR_W'(1);
    end else if (advance) begin
      if (wrap) begin
        col_d  = COL_FIRST;
        row_d  = row_q + RW'(1);
        base_d = base_q + W_STEP;
        addr_d = base_q + W_STEP + ADDR_W'(1);
      end else begin
        col_d  = col_q + CW'(1);
        addr_d = addr_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q  <= '0;
      row_q  <= '0;
      base_q <= '0;
      addr_q <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      base_q <= base_d;
      addr_q <= addr_d;
    end
  end

  assign addr = addr_q;
  assign last = wrap && (row_q == ROW_LAST);

endmodule

// File: rtl/sobel_scan_ctrl.sv
// rtl/sobel_scan_ctrl.sv - frame sequencer for window requests and Sobel output tagging
module sobel_scan_ctrl
  import sobel_pkg::*;
#(
  parameter int IMG_W    = IMG_W_DEF,
  parameter int IMG_H    = IMG_H_DEF,
  parameter int ADDR_W   = 16,
  parameter int PIPE_LAT = PIPE_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              pause,
  output logic              win_req,
  input  logic              win_ack,
  output logic [ADDR_W-1:0] win_addr,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_idx,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int                N        = num_windows(IMG_W, IMG_H);
  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(N - 1);

  scan_state_t         state_q, state_d;
  logic [PIPE_LAT-1:0] vld_q, vld_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                accept;
  logic                scan_last;
  logic                load;

  assign win_req = (state_q == RUN) && !pause;
  assign accept  = win_req && win_ack;
  assign load    = (state_q == IDLE) && start && !abort;

  raster_counter #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W)
  ) u_raster (
    .clk     (clk),
    .rst_n   (rst),
    .clear   (abort),
    .load    (load),
    .advance (accept),
    .addr    (win_addr),
    .last    (scan_last)
  );

  always_comb begin
    state_d = state_q;
    vld_d   = PIPE_LAT'({vld_q, accept});
    idx_d   = out_valid ? idx_q + ADDR_W'(1) : idx_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          idx_d   = '0;
        end
      end
      RUN: begin
        if (accept && scan_last) state_d = DRAIN;
      end
      // Leave on the edge where the final result is consumed, so done follows it directly.
      DRAIN: begin
        if (vld_d == '0) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      vld_d   = '0;
      idx_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      vld_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      idx_q   <= idx_d;
    end
  end

  assign out_valid = vld_q[PIPE_LAT-1];
  assign out_idx   = idx_q;
  assign out_last  = out_valid && (idx_q == IDX_LAST);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_sobel_scan_ctrl.sv
// tb/tb_sobel_scan_ctrl.sv - self-checking bench for sobel_scan_ctrl on a 5x4 image
module tb_sobel_scan_ctrl;

  localparam int IMG_W    = 5;
  localparam int IMG_H    = 4;
  localparam int ADDR_W   = 16;
  localparam int PIPE_LAT = 2;
  localparam int N        = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              pause = 1'b0;
  logic              win_ack = 1'b0;
  logic              win_req;
  logic [ADDR_W-1:0] win_addr;
  logic              out_valid;
  logic [ADDR_W-1:0] out_idx;
  logic              out_last;
  logic              busy;
  logic              done;

  sobel_scan_ctrl #(
    .IMG_W    (IMG_W),
    .IMG_H    (IMG_H),
    .ADDR_W   (ADDR_W),
    .PIPE_LAT (PIPE_LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .pause     (pause),
    .win_req   (win_req),
    .win_ack   (win_ack),
    .win_addr  (win_addr),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    bit last;
    int due;
  } exp_t;

  typedef struct {
    string      name;
    logic [7:0] ack_pat;
    int         pause_from;
    int         pause_len;
    bit         ign_start;
    int         done_rel;
  } vec_t;

  exp_t sb[$];
  exp_t e;
  vec_t vecs[5];
  int   exp_addr[N] = '{6, 7, 8, 11, 12, 13};

  int nchk = 0;
  int nerr = 0;
  int cyc = 0;
  int addr_ptr = 0;
  int push_idx = 0;
  int out_cnt = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int start_cyc = 0;

  function automatic void check(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Scoreboard: acceptances push expected results, out_valid pops and compares.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      sb.delete();
    end else begin
      if (sb.size() > 0 && sb[0].due < cyc) begin
        check("out_time_missed", cyc, sb[0].due);
        void'(sb.pop_front());
      end
      if (out_valid) begin
        out_cnt++;
        if (sb.size() == 0) begin
          check("out_valid_unexpected", out_valid, 0);
        end else begin
          e = sb.pop_front();
          check("out_idx", out_idx, e.idx);
          check("out_last", out_last, e.last);
          check("out_time", cyc, e.due);
        end
      end else begin
        check("out_last_idle", out_last, 0);
      end
      if (pause) check("win_req_paused", win_req, 0);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (abort) begin
        sb.delete();
      end else if (win_req && win_ack) begin
        if (addr_ptr < N) check("win_addr", win_addr, exp_addr[addr_ptr]);
        else check("accept_count_over", addr_ptr + 1, N);
        sb.push_back('{idx: push_idx, last: (push_idx == N - 1), due: cyc + PIPE_LAT});
        addr_ptr++;
        push_idx++;
      end
    end
  end

  task automatic model_reset();
    sb.delete();
    addr_ptr = 0;
    push_idx = 0;
    out_cnt  = 0;
    done_cnt = 0;
    done_cyc = 0;
  endtask

  task automatic run_frame(input vec_t v);
    model_reset();
    @(posedge clk); #1;
    start     = 1'b1;
    start_cyc = cyc + 1;
    for (int k = 1; k <= 24; k++) begin
      @(posedge clk); #1;
      win_ack = v.ack_pat[(k - 1) % 8];
      pause   = (v.pause_from > 0) && (k >= v.pause_from) && (k < v.pause_from + v.pause_len);
      start   = v.ign_start && (k == 3 || k == v.done_rel);
    end
    win_ack = 1'b0;
    pause   = 1'b0;
    start   = 1'b0;
    check($sformatf("%s/done_count", v.name), done_cnt, 1);
    check($sformatf("%s/done_time", v.name), done_cyc - start_cyc, v.done_rel);
    check($sformatf("%s/out_count", v.name), out_cnt, N);
    check($sformatf("%s/accept_count", v.name), addr_ptr, N);
    check($sformatf("%s/sb_empty", v.name), sb.size(), 0);
    check($sformatf("%s/busy_after", v.name), busy, 0);
  endtask

  initial begin
    vecs[0] = '{"nominal",      8'hFF, 0, 0, 1'b0,  9};
    vecs[1] = '{"ack_toggle",   8'h55, 0, 0, 1'b0, 14};
    vecs[2] = '{"pause_mid",    8'hFF, 4, 3, 1'b0, 12};
    vecs[3] = '{"ack_late",     8'hF0, 0, 0, 1'b0, 17};
    vecs[4] = '{"ignored_start", 8'hFF, 0, 0, 1'b1,  9};

    repeat (3) @(posedge clk);
    #1;
    check("rst_win_req", win_req, 0);
    check("rst_win_addr", win_addr, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 5; i++) run_frame(vecs[i]);

    // Abort after three acceptances, then a clean restart.
    model_reset();
    @(posedge clk); #1;
    start   = 1'b1;
    win_ack = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort/busy", busy, 0);
    check("abort/out_valid", out_valid, 0);
    repeat (6) @(posedge clk);
    #1;
    win_ack = 1'b0;
    check("abort/accept_count", addr_ptr, 3);
    check("abort/out_count", out_cnt, 2);
    check("abort/done_count", done_cnt, 0);
    check("abort/sb_empty", sb.size(), 0);
    run_frame(vecs[0]);

    // Asynchronous reset while draining.
    model_reset();
    @(posedge clk); #1;
    start   = 1'b1;
    win_ack = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("rst_drain/win_req", win_req, 0);
    check("rst_drain/win_addr", win_addr, 0);
    check("rst_drain/out_valid", out_valid, 0);
    check("rst_drain/out_idx", out_idx, 0);
    check("rst_drain/out_last", out_last, 0);
    check("rst_drain/busy", busy, 0);
    check("rst_drain/done", done, 0);
    @(posedge clk); #1;
    rst     = 1'b1;
    win_ack = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("rst_drain/out_count", out_cnt, N - 1);
    check("rst_drain/done_count", done_cnt, 0);
    check("rst_drain/busy_after", busy, 0);
    run_frame(vecs[0]);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/sobel_scan_ctrl.md
# sobel_scan_ctrl

Frame-level controller that sequences the 3×3 window fetch and Sobel datapath. On `start` it walks every interior pixel of an `IMG_W`×`IMG_H` image in raster order and issues one window request per centre pixel to the memory reader. It tracks the fixed Sobel pipeline latency so that each 8-bit result is tagged with `out_valid`, an output index and `out_last`. It signals `done` once the last result has left the pipeline. It sits between the top-level/testbench control and the `memory_reader` → `main_sobel` chain.

## Interface
Parameters:
- `IMG_W`, 256: image width in pixels; must be ≥ 3.
- `IMG_H`, 256: image height in pixels; must be ≥ 3.
- `ADDR_W`, 16: pixel address width; 2^ADDR_W ≥ IMG_W·IMG_H.
- `PIPE_LAT`, 2: cycles from window acceptance to a valid Sobel result; must be ≥ 1.

Ports:
- `clk`  in  1: single clock; all logic on rising edge.
- `rst`  in  1: reset, asynchronous, active-low.
- `start`  in  1: one-cycle request to process a frame; honoured only in IDLE.
- `abort`  in  1: synchronous cancel; returns to IDLE from any state.
- `pause`  in  1: downstream hold; blocks new window requests only.
- `win_req`  out  1: window request to the memory reader.
- `win_ack`  in  1: memory reader accepts the current `win_addr`.
- `win_addr`  out  ADDR_W: centre pixel address, row·IMG_W+col.
- `out_valid`  out  1: the Sobel `bus_out` is valid this cycle.
- `out_idx`  out  ADDR_W: running index of the valid output, starting at 0.
- `out_last`  out  1: qualifies the final output of the frame.
- `busy`  out  1: high when the state is not IDLE.
- `done`  out  1: one-cycle pulse at the end of the frame.

## Operation
- **States.** IDLE, RUN, DRAIN, DONE.
- **IDLE.**
  - `start`=1 → RUN.
  - On entry to RUN: row=1, col=1, `win_addr`=IMG_W+1, `out_idx`=0.
- **RUN.**
  - `win_req` = (state==RUN) && !`pause`. This is combinational from the registered state.
  - A window is accepted when `win_req`&&`win_ack` at an edge.
  - On acceptance, col increments. At col==IMG_W-2, col wraps to 1 and row increments. `win_addr` is updated in the same edge.
  - When the accepted window is (IMG_H-2, IMG_W-2) → DRAIN.
  - `win_addr` is held stable while not accepted.
- **Valid pipeline.**
  - Shift register `vld_sr[PIPE_LAT-1:0]` shifts every cycle, regardless of `pause`.
  - Bit 0 is loaded with the acceptance flag.
  - `out_valid` = `vld_sr[PIPE_LAT-1]`.
- **Output index.**
  - `out_idx` increments after each cycle in which `out_valid`=1.
  - `out_last` = `out_valid` && (`out_idx`==N-1), where N=(IMG_W-2)(IMG_H-2).
- **DRAIN.** When `vld_sr`==0 → DONE.
- **DONE.** `done`=1 for exactly one cycle, then → IDLE. `start` is ignored in DONE.
- **`abort`.**
  - Takes priority over all transitions.
  - Next state is IDLE; clears `vld_sr`, counters, `out_idx`.
  - No `done` pulse is produced.
- **`start` outside IDLE.** Ignored.
- **Async reset.** Valid mid-frame; it discards all in-flight windows.
- **Arithmetic.**
  - row/col counters are `$clog2(IMG_H)` / `$clog2(IMG_W)` bits wide.
  - The address is built by a row-base accumulator (+IMG_W per row), not a multiplier. Result width is ADDR_W, unsigned.

## Timing
- **Reset values.**
  - state=IDLE, `win_req`=0, `win_addr`=0, `out_valid`=0, `out_idx`=0, `out_last`=0, `busy`=0, `done`=0, `vld_sr`=0.
- **Start.** `start` sampled at edge t → `busy`=1 and `win_req`=1 in the cycle following edge t.
- **Throughput.** One window per cycle when `win_ack`=1 and `pause`=0.
- **Latency.** A window accepted at edge e has `out_valid`=1 sampled at edge e+PIPE_LAT, the same edge the consumer samples `bus_out`.
- **Frame duration.** With `win_ack` tied high and no pause:
  - last acceptance at edge t+N;
  - `out_last` sampled at edge t+N+PIPE_LAT;
  - `done` high in the cycle after edge t+N+PIPE_LAT;
  - `busy` low one cycle later.
- **Pause.** `pause` asserted in the cycle of a would-be acceptance → no acceptance; already-accepted results still emerge on schedule.

## Structure
- Shared package `sobel_pkg`:
  - state enum `scan_state_t` (IDLE, RUN, DRAIN, DONE);
  - default `IMG_W`/`IMG_H`/`PIPE_LAT` constants;
  - localparam function for N.
- Sub-module `raster_counter` (col/row/row-base with wrap and last flag), instantiated once for the request side.
- The FSM, valid shift register and output counter live in the top module.

## Test plan
- **Nominal frame.** IMG_W=5, IMG_H=4, PIPE_LAT=2, `win_ack`=1. Pulse `start` → `win_addr` sequence 6,7,8,11,12,13 on consecutive cycles. Six `out_valid` cycles with `out_idx` 0–5, `out_last` only on idx 5. `done` pulses once, two cycles after the last acceptance.
- **Ack backpressure.** `win_ack` toggles 1,0,1,0… → each address is held until acked, none is skipped. Six outputs in total; each `out_valid` arrives exactly PIPE_LAT edges after its acceptance.
- **Pause mid-frame.** `pause`=1 for 3 cycles after address 8 is accepted → `win_req`=0 during the pause. Output for address 8 still appears on time. Resumes at address 11.
- **Abort in RUN.** Assert `abort` after 3 acceptances → IDLE next cycle, `vld_sr` cleared. No further `out_valid`, no `done`. A new `start` restarts at address 6 with `out_idx`=0.
- **Reset mid-DRAIN.** Drive `rst`=0 asynchronously between edges → all outputs go to reset values immediately, `busy`=0.
- **Ignored start.** `start` while `busy`=1 and during DONE → no restart and no extra frame. Total outputs equal 6.
